// File: rtl/req_onehot_arbiter.sv
// Synchronises eight async request lines, queues their rising edges and grants one line at a
// time as a registered one-hot word. Define REQ_ARB_ROUND_ROBIN_EN for round-robin arbitration.
module req_onehot_arbiter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req_i,
    input  logic       ready_i,
    output logic [7:0] d_o,
    output logic       valid_o,
    output logic [7:0] pend_o,
    output logic       overrun_o
);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e     state_q;
    logic [7:0] s1_q, s2_q, s3_q;
    logic [7:0] pend_q;
    logic [7:0] d_q;
    logic       valid_q;
    logic       overrun_q;
    logic [7:0] rise;
    logic [7:0] cand;
    logic [7:0] sel_oh;
    logic [2:0] sel_idx;
`ifdef REQ_ARB_ROUND_ROBIN_EN
    logic [2:0] ptr_q;
    logic [2:0] scan_idx;
`endif

    assign rise = s2_q & ~s3_q;
    assign cand = pend_q | rise;

    always_comb begin
        sel_idx = 3'd0;
`ifdef REQ_ARB_ROUND_ROBIN_EN
        // Scan from the farthest slot back toward ptr_q+1 so the nearest candidate is written last.
        scan_idx = 3'd0;
        for (int n = 8; n >= 1; n--) begin
            scan_idx = ptr_q + 3'(n);
            if (cand[scan_idx]) sel_idx = scan_idx;
        end
`else
        for (int i = 0; i < 8; i++) begin
            if (cand[i]) sel_idx = 3'(i);
        end
`endif
        sel_oh = 8'd1 << sel_idx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q      <= '0;
            s2_q      <= '0;
            s3_q      <= '0;
            pend_q    <= '0;
            d_q       <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            state_q   <= StIdle;
`ifdef REQ_ARB_ROUND_ROBIN_EN
            ptr_q     <= 3'd7;
`endif
        end else begin
            s1_q      <= req_i;
            s2_q      <= s1_q;
            s3_q      <= s2_q;
            // An edge on the granted line is not pending, so it is re-queued, not flagged.
            overrun_q <= |(rise & pend_q);
            case (state_q)
                StIdle: begin
                    if (|cand) begin
                        d_q     <= sel_oh;
                        valid_q <= 1'b1;
                        pend_q  <= cand & ~sel_oh;
                        state_q <= StGrant;
`ifdef REQ_ARB_ROUND_ROBIN_EN
                        ptr_q   <= sel_idx;
`endif
                    end
                end
                StGrant: begin
                    pend_q <= pend_q | rise;
                    if (ready_i) begin
                        d_q     <= '0;
                        valid_q <= 1'b0;
                        state_q <= StIdle;
                    end
                end
            endcase
        end
    end

    assign d_o       = d_q;
    assign valid_o   = valid_q;
    assign pend_o    = pend_q;
    assign overrun_o = overrun_q;

endmodule

// File: tb/tb_req_onehot_arbiter.sv
// Bench for req_onehot_arbiter: directed scenarios with literal expectations plus a per-cycle
// compare against a behavioural pending-set model.
module tb_req_onehot_arbiter;

`ifdef REQ_ARB_ROUND_ROBIN_EN
    localparam bit RoundRobin = 1'b1;
`else
    localparam bit RoundRobin = 1'b0;
`endif

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req   = 8'h00;
    logic       ready = 1'b1;
    logic [7:0] d_o;
    logic       valid_o;
    logic [7:0] pend_o;
    logic       overrun_o;

    always #5 clk = ~clk;

    req_onehot_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_i     (req),
        .ready_i   (ready),
        .d_o       (d_o),
        .valid_o   (valid_o),
        .pend_o    (pend_o),
        .overrun_o (overrun_o)
    );

    int total = 0;
    int bad   = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Model: raw samples of req, a set of pending lines, and who (if anyone) holds the grant.
    logic [7:0] hist [3];
    bit         m_pend [8];
    bit         m_busy;
    int         m_line;
    int         m_ptr;
    bit         m_ovr;
    int         acc, acc08, lost, edges, ovr_pulses;
    logic [7:0] prev_req;

    function automatic void model_reset();
        for (int i = 0; i < 3; i++) hist[i] = 8'h00;
        for (int i = 0; i < 8; i++) m_pend[i] = 1'b0;
        m_busy = 1'b0;
        m_line = 0;
        m_ptr  = 7;
        m_ovr  = 1'b0;
    endfunction

    function automatic void model_step();
        bit r [8];
        bit cand [8];
        int k;
        m_ovr = 1'b0;
        for (int i = 0; i < 8; i++) r[i] = hist[1][i] && !hist[2][i];
        for (int i = 0; i < 8; i++) begin
            if (r[i] && m_pend[i]) begin
                m_ovr = 1'b1;
                lost++;
            end
        end
        if (!m_busy) begin
            for (int i = 0; i < 8; i++) cand[i] = m_pend[i] || r[i];
            k = -1;
            if (RoundRobin) begin
                for (int n = 1; n <= 8; n++) begin
                    if (k < 0 && cand[(m_ptr + n) % 8]) k = (m_ptr + n) % 8;
                end
            end else begin
                for (int j = 7; j >= 0; j--) if (k < 0 && cand[j]) k = j;
            end
            if (k >= 0) begin
                m_busy = 1'b1;
                m_line = k;
                m_ptr  = k;
                for (int i = 0; i < 8; i++) m_pend[i] = cand[i] && (i != k);
            end
        end else begin
            if (ready) m_busy = 1'b0;
            for (int i = 0; i < 8; i++) m_pend[i] = m_pend[i] || r[i];
        end
        hist[2] = hist[1];
        hist[1] = hist[0];
        hist[0] = req;
    endfunction

    initial begin
        logic [7:0] pk;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                model_reset();
            end else begin
                if (valid_o && ready) begin
                    acc++;
                    if (d_o == 8'h08) acc08++;
                end
                model_step();
            end
            #1;
            pk = 8'h00;
            for (int i = 0; i < 8; i++) pk[i] = m_pend[i];
            if (overrun_o) ovr_pulses++;
            chk("mdl_valid", {31'd0, valid_o}, {31'd0, m_busy});
            chk("mdl_d", {24'd0, d_o}, m_busy ? (32'd1 << m_line) : 32'd0);
            chk("mdl_pend", {24'd0, pend_o}, {24'd0, pk});
            chk("mdl_overrun", {31'd0, overrun_o}, {31'd0, m_ovr});
            chk("inv_onehot", {31'd0, $countones(d_o) <= 1}, 32'd1);
            chk("inv_zero_idle", {31'd0, valid_o || (d_o == 8'h00)}, 32'd1);
        end
    end

    task automatic drive(input logic [7:0] v);
        edges += $countones(v & ~prev_req);
        prev_req = v;
        req = v;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(input logic [7:0] v);
        @(negedge clk);
        rst_n = 1'b0;
        drive(v);
        tick(2);
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, o0, a8, cnt;
        acc = 0; acc08 = 0; lost = 0; edges = 0; ovr_pulses = 0; prev_req = 8'h00;
        tick(3);
        chk("rst_valid", {31'd0, valid_o}, 32'd0);
        chk("rst_d", {24'd0, d_o}, 32'd0);
        chk("rst_pend", {24'd0, pend_o}, 32'd0);
        rst_n = 1'b1;

        // Single request; a held line yields one grant only.
        ready = 1'b1;
        drive(8'h10);
        tick(1); chk("t1_e0_valid", {31'd0, valid_o}, 32'd0);
        tick(1); chk("t1_e1_valid", {31'd0, valid_o}, 32'd0);
        tick(1); chk("t1_d", {24'd0, d_o}, 32'h10);
        chk("t1_valid", {31'd0, valid_o}, 32'd1);
        a0 = acc;
        tick(1); chk("t1_drop", {31'd0, valid_o}, 32'd0);
        chk("t1_pend", {24'd0, pend_o}, 32'd0);
        tick(10); chk("t1_one_grant", acc - a0, 32'd1);

        // Simultaneous requests on lines 0 and 7.
        do_reset(8'h00);
        drive(8'h81);
        tick(3); chk("t2_first", {24'd0, d_o}, RoundRobin ? 32'h01 : 32'h80);
        tick(1); chk("t2_idle", {31'd0, valid_o}, 32'd0);
        tick(1); chk("t2_second", {24'd0, d_o}, RoundRobin ? 32'h80 : 32'h01);
        tick(1); chk("t2_done", {31'd0, valid_o}, 32'd0);

        // Backpressure with line 6 rising during the stall.
        drive(8'h00); tick(4);
        ready = 1'b0;
        drive(8'h04);
        tick(3); chk("t3_grant", {24'd0, d_o}, 32'h04);
        drive(8'h44);
        for (int i = 0; i < 5; i++) begin
            tick(1);
            chk("t3_hold", {23'd0, valid_o, d_o}, 32'h104);
        end
        chk("t3_pend", {24'd0, pend_o}, 32'h40);
        ready = 1'b1;
        tick(1); chk("t3_accept", {31'd0, valid_o}, 32'd0);
        tick(1); chk("t3_next", {24'd0, d_o}, 32'h40);
        tick(1);

        // Two pulses on line 3 while stalled: merged and flagged once.
        drive(8'h00); tick(4);
        ready = 1'b0;
        drive(8'h01);
        tick(3); chk("t4_stall", {24'd0, d_o}, 32'h01);
        o0 = ovr_pulses;
        a8 = acc08;
        drive(8'h09); tick(3);
        drive(8'h01); tick(3);
        drive(8'h09); tick(3);
        drive(8'h01); tick(4);
        chk("t4_pend", {24'd0, pend_o}, 32'h08);
        chk("t4_overrun", ovr_pulses - o0, 32'd1);
        ready = 1'b1;
        tick(1); chk("t4_accept", {31'd0, valid_o}, 32'd0);
        tick(1); chk("t4_grant3", {24'd0, d_o}, 32'h08);
        tick(8); chk("t4_one_grant3", acc08 - a8, 32'd1);

        // Asynchronous reset while granting with lines 1 and 5 pending.
        drive(8'h00); tick(4);
        ready = 1'b0;
        drive(8'h01);
        tick(3); chk("t5_grant", {24'd0, d_o}, 32'h01);
        drive(8'h23);
        tick(3); chk("t5_pend", {24'd0, pend_o}, 32'h22);
        rst_n = 1'b0;
        drive(8'h00);
        #1;
        chk("t5_rst_valid", {31'd0, valid_o}, 32'd0);
        chk("t5_rst_d", {24'd0, d_o}, 32'd0);
        chk("t5_rst_pend", {24'd0, pend_o}, 32'd0);
        tick(2);
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            if (valid_o) cnt++;
        end
        chk("t5_no_grant", cnt, 32'd0);

        // A line already high at reset release gives exactly one request.
        do_reset(8'h04);
        tick(3); chk("t6_rel_grant", {24'd0, d_o}, 32'h04);
        ready = 1'b1;
        tick(1);
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            if (valid_o) cnt++;
        end
        chk("t6_rel_once", cnt, 32'd0);

        // Random traffic; every edge is either granted or flagged as merged.
        do_reset(8'h00);
        edges = 0; acc = 0; lost = 0; prev_req = 8'h00;
        for (int i = 0; i < 2000; i++) begin
            drive(req ^ 8'($urandom & $urandom & $urandom));
            ready = ($urandom_range(0, 3) != 0);
            tick(1);
        end
        ready = 1'b1;
        tick(30);
        chk("rnd_drained", {23'd0, valid_o, pend_o}, 32'd0);
        chk("rnd_conserve", acc + lost, edges);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
